// File: rtl/step_debounce.sv
// rtl/step_debounce.sv - push-button synchroniser, debouncer and step/auto-repeat pulse generator
//
// Purpose:
//   Turns a raw, bouncing, asynchronous push-button level into clean
//   single-cycle step pulses for a downstream same-domain counter.
//   btn_in -> two-flop synchroniser -> stable-sample debounce counter ->
//   IDLE/HOLD/REPEAT state machine that issues the step pulses.
//
// Build option:
//   AUTO_REPEAT_EN - when defined, holding the button issues a repeat step
//                    REPEAT_DELAY cycles after the first step and then every
//                    REPEAT_PERIOD cycles. When undefined, one step per press
//                    and repeating is held at 0.
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous active-low reset
//   btn_in     in   raw button level (asynchronous), 1 = pressed
//   pressed    out  debounced button level (registered)
//   step       out  one-cycle pulse per accepted press or repeat (registered)
//   repeating  out  high while in the auto-repeat state (registered)

module step_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pressed,
    output logic step,
    output logic repeating
);

    // Elaboration-time sanity check on the configuration.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("step_debounce: DEBOUNCE_CYCLES must be >= 1, REPEAT_DELAY and REPEAT_PERIOD >= 2");
    end

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic          s0_q, s1_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pressed_q, pressed_d;
    logic          step_q, step_d;
    logic          repeating_q, repeating_d;
    state_t        state_q, state_d;
    logic          rise, fall;

    // ------------------------------------------------------------------
    // Synchroniser and debounce registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
        end else begin
            s0_q      <= btn_in;
            s1_q      <= s0_q;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
        end
    end

    // Count consecutive synchronised samples that disagree with the
    // accepted level; any agreeing sample restarts the count, so a glitch
    // shorter than DEBOUNCE_CYCLES samples is never accepted.
    always_comb begin
        cnt_d     = '0;
        pressed_d = pressed_q;
        if (s1_q != pressed_q) begin
            if (cnt_q == CNT_LAST) begin
                pressed_d = ~pressed_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // The FSM reacts to the edge being accepted this cycle so that the
    // first step rises together with pressed.
    assign rise = pressed_d & ~pressed_q;
    assign fall = ~pressed_d & pressed_q;

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(RMAX);
    localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);

    logic [TW-1:0] timer_q, timer_d;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            step_q      <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            step_q      <= step_d;
            repeating_q <= repeating_d;
        end
    end

    // Next-state logic; a release always wins over a timer expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (fall)                 state_d = ST_IDLE;
                else if (timer_q == '0)   state_d = ST_REPEAT;
            end
            ST_REPEAT: begin
                if (fall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / timer logic. The timer is reloaded or cleared whenever it
    // is at zero, so it never wraps.
    always_comb begin
        step_d  = 1'b0;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    step_d  = 1'b1;
                    timer_d = DELAY_LOAD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (fall) begin
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    step_d  = 1'b1;
                    timer_d = PERIOD_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                timer_d = '0;
            end
        endcase
        repeating_d = (state_d == ST_REPEAT);
    end
`else
    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            step_q      <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            repeating_q <= repeating_d;
        end
    end

    // Next-state logic: IDLE on release, HOLD while pressed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (fall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: a single step on entry to HOLD, never a repeat.
    always_comb begin
        step_d      = (state_q == ST_IDLE) && rise;
        repeating_d = 1'b0;
    end
`endif

    assign pressed   = pressed_q;
    assign step      = step_q;
    assign repeating = repeating_q;

endmodule

// File: tb/tb_step_debounce.sv
// tb/tb_step_debounce.sv - self-checking bench for step_debounce
//
// Drives directed and $urandom button patterns and compares every cycle
// against a reference model that derives step times arithmetically from
// the cycles elapsed since the debounced press.

module tb_step_debounce;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

`ifdef AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic pressed;
    logic step;
    logic repeating;

    step_debounce #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .pressed   (pressed),
        .step      (step),
        .repeating (repeating)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_sa, m_sb;
    int m_run;
    bit m_pressed, m_step, m_rep;
    int m_held;

    // Per-phase observation counters
    int ph_n, ph_steps, ph_rep, ph_press, ph_first, ph_last;
    int adj_steps = 0;
    bit last_step = 1'b0;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_sa = 0; m_sb = 0; m_run = 0;
        m_pressed = 0; m_step = 0; m_rep = 0; m_held = 0;
    endtask

    // One clock edge of the behavioural model: b is btn_in at that edge.
    task automatic model_edge(input bit b);
        bit was;
        was = m_pressed;
        if (m_sb != m_pressed) begin
            m_run++;
            if (m_run == D) begin
                m_pressed = !m_pressed;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_sb = m_sa;
        m_sa = b;
        if (m_pressed && !was) begin
            m_held = 0;
            m_step = 1;
        end else if (m_pressed) begin
            m_held++;
            m_step = REP_EN && (m_held >= RD) && (((m_held - RD) % RP) == 0);
        end else begin
            m_held = 0;
            m_step = 0;
        end
        m_rep = REP_EN && m_pressed && (m_held >= RD);
    endtask

    task automatic phase_clear();
        ph_n = 0; ph_steps = 0; ph_rep = 0; ph_press = 0;
        ph_first = -1; ph_last = -1;
    endtask

    // Drive b, let one rising edge pass, then compare on the falling edge.
    task automatic tick(input bit b);
        btn_in = b;
        @(posedge clk);
        if (reset) model_edge(b);
        @(negedge clk);
        check_bit("pressed", pressed, m_pressed);
        check_bit("step", step, m_step);
        check_bit("repeating", repeating, m_rep);
        ph_n++;
        if (step) ph_steps++;
        if (repeating) ph_rep++;
        if (pressed) begin
            ph_press++;
            if (ph_first < 0) ph_first = ph_n;
            ph_last = ph_n;
        end
        if (step && last_step) adj_steps++;
        last_step = step;
    endtask

    initial begin
        reset  = 1'b0;
        btn_in = 1'b0;
        model_clear();
        phase_clear();
        repeat (3) @(negedge clk);
        check_bit("reset_pressed", pressed, 1'b0);
        check_bit("reset_step", step, 1'b0);
        check_bit("reset_repeating", repeating, 1'b0);
        reset = 1'b1;

        // Clean press: 8 cycles high
        phase_clear();
        repeat (8) tick(1'b1);
        repeat (12) tick(1'b0);
        check_int("clean_steps", ph_steps, 1);
        check_int("clean_rise_tick", ph_first, 6);
        check_int("clean_last_high_tick", ph_last, 13);

        // Bounce: toggle every 2 cycles for 20 cycles, then hold high
        phase_clear();
        for (int i = 0; i < 20; i++) tick(((i / 2) % 2) == 0);
        repeat (8) tick(1'b1);
        repeat (12) tick(1'b0);
        check_int("bounce_steps", ph_steps, 1);
        check_int("bounce_rise_tick", ph_first, 26);

        // Random short glitches never accepted
        phase_clear();
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(1, D - 1)) tick(1'b1);
            repeat ($urandom_range(1, 5)) tick(1'b0);
        end
        repeat (8) tick(1'b0);
        check_int("glitch_press_cycles", ph_press, 0);
        check_int("glitch_steps", ph_steps, 0);

        // Auto-repeat: hold 40 cycles
        phase_clear();
        repeat (40) tick(1'b1);
        repeat (12) tick(1'b0);
        check_int("hold40_steps", ph_steps, REP_EN ? 11 : 1);
        check_int("hold40_repeat_cycles", ph_rep, REP_EN ? 30 : 0);

        // Release collides with a repeat expiry (cycles-since-press = 16)
        phase_clear();
        repeat (16) tick(1'b1);
        repeat (12) tick(1'b0);
        check_int("collide_steps", ph_steps, REP_EN ? 3 : 1);
        check_int("collide_repeat_cycles", ph_rep, REP_EN ? 6 : 0);
        check_int("collide_last_high_tick", ph_last, 21);

        // Random button runs checked cycle by cycle
        phase_clear();
        for (int i = 0; i < 30; i++) begin
            bit b;
            b = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 25)) tick(b);
        end
        repeat (12) tick(1'b0);

        // Reset in the middle of a hold, button kept pressed
        phase_clear();
        repeat (18) tick(1'b1);
        check_bit("pre_reset_pressed", pressed, 1'b1);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check_bit("rst_mid_pressed", pressed, 1'b0);
        check_bit("rst_mid_step", step, 1'b0);
        check_bit("rst_mid_repeating", repeating, 1'b0);
        @(negedge clk);
        repeat (2) tick(1'b1);
        reset = 1'b1;
        phase_clear();
        repeat (20) tick(1'b1);
        check_int("post_reset_steps", ph_steps, REP_EN ? 3 : 1);
        check_int("post_reset_rise_tick", ph_first, 6);
        repeat (12) tick(1'b0);

        check_int("adjacent_steps", adj_steps, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/step_debounce.md
# step_debounce

Conditions a raw mechanical push-button into clean single-cycle step pulses with optional auto-repeat. It sits directly upstream of the 4-bit up-counter and supplies the pulse that advances the count. It synchronises the asynchronous button, debounces it with a cycle counter, and runs a small hold/repeat state machine.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples required to accept a new level; must be ≥1.
- REPEAT_DELAY, 500: cycles from the first step to the first repeat step; must be ≥2.
- REPEAT_PERIOD, 100: cycles between subsequent repeat steps; must be ≥2.
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
- btn_in  input  1  raw button level, asynchronous to clk, 1 = pressed.
- pressed  output  1  debounced button level, registered.
- step  output  1  one-cycle pulse per accepted press or repeat, registered.
- repeating  output  1  high while auto-repeat steps are being issued, registered.

## Operation
- Synchroniser: two flops (s0 ← btn_in, s1 ← s0); both reset to 0. All logic uses only s1.
- Debounce counter:
  - Width is clog2(DEBOUNCE_CYCLES+1).
  - Increments each cycle while s1 ≠ pressed. Clears to 0 on any cycle where s1 = pressed.
  - When the count would reach DEBOUNCE_CYCLES, pressed toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes pressed.
- FSM states:
  - IDLE. pressed rises → issue step, load repeat timer with REPEAT_DELAY-1, go to HOLD.
  - HOLD. Timer decrements each cycle. At 0 → step, reload REPEAT_PERIOD-1, go to REPEAT.
  - REPEAT. At 0 → step, reload REPEAT_PERIOD-1, stay.
  - pressed falling in HOLD or REPEAT → IDLE, timer cleared, no step.
- Repeat timer width is clog2(max(REPEAT_DELAY, REPEAT_PERIOD)). It never wraps; it is always reloaded or cleared at 0.
- repeating = 1 exactly while in REPEAT.
- Reset values: pressed=0, step=0, repeating=0, FSM=IDLE, all counters 0, sync flops 0.

## Timing
- Press latency: btn_in sampled high at edge k → s1 high after edge k+1. pressed and the first step rise together after edge k+1+DEBOUNCE_CYCLES.
- Release latency has the same structure; there is no step on release.
- step is always exactly one cycle wide. It is never asserted in two consecutive cycles.
- First repeat step comes REPEAT_DELAY cycles after the first step. Later repeats follow every REPEAT_PERIOD cycles while pressed=1.
- Simultaneous events: on the edge where pressed falls and the timer reaches 0, the release wins and no step is issued.
- Reset mid-operation: all outputs drop asynchronously; no step is emitted on reset release.
  - If the button is still held at reset release, it is treated as a new press: step after 2+DEBOUNCE_CYCLES cycles.
- step is intended to be used by the downstream counter as a synchronous count enable in the same clk domain.

## Configuration
- AUTO_REPEAT_EN defined: HOLD/REPEAT behaviour as described; REPEAT_DELAY and REPEAT_PERIOD are honoured.
- AUTO_REPEAT_EN undefined:
  - Exactly one step per debounced press.
  - The FSM reduces to IDLE/HOLD with no timer.
  - repeating is tied to 0; the repeat parameters are ignored.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, AUTO_REPEAT_EN defined.
- Clean press: btn_in high from edge 0 for 8 cycles → pressed and step rise after edge 5; step high one cycle; no further step; pressed falls 6 cycles after btn_in falls.
- Bounce: btn_in toggles every 2 cycles for 20 cycles, then held high → pressed stays 0 during bouncing; exactly one step after 6 stable cycles.
- Auto-repeat: hold btn_in high for 40 cycles → steps at relative cycles 0, 10, 13, 16, 19, …; repeating high from the second step until release is debounced.
- Release collision: time the debounced release to coincide with a repeat timer expiry → no step that cycle; FSM returns to IDLE.
- Reset mid-hold: assert reset during REPEAT with btn_in held → outputs 0 immediately. Deassert → exactly one step 6 cycles later, then repeats resume from REPEAT_DELAY.
- AUTO_REPEAT_EN undefined: hold 40 cycles → exactly one step; repeating stays 0 throughout.
